// File: rtl/alu_control_seq.sv
// EX-stage ALU control: registered ALUOp/funct decode with a busy counter that
// sequences multi-cycle MUL/DIV and stalls the ID/EX stage while they run.
module alu_control_seq #(
   parameter int FUNCT_W    = 6,
   parameter int CTL_W      = 4,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 16,
   parameter int CNT_W      = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               valid_in,
   input  logic [1:0]         alu_op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               flush,
   output logic [CTL_W-1:0]   ctl_out,
   output logic               ctl_valid,
   output logic               busy,
   output logic               done,
   output logic               illegal
);

   typedef enum logic {IDLE, MULTI} state_t;

   typedef struct packed {
      logic [3:0] code;
      logic       ill;
      logic       is_mul;
      logic       is_div;
   } dec_t;

   localparam logic [3:0] C_AND = 4'h0, C_OR  = 4'h1, C_ADD = 4'h2, C_XOR = 4'h3,
                          C_SUB = 4'h6, C_SLT = 4'h7, C_SLL = 4'h8, C_SRL = 4'h9,
                          C_MUL = 4'hC, C_DIV = 4'hD, C_NOP = 4'hF;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   dec_t               w_dec;
   logic [FUNCT_W-1:0] w_hi;
   logic [5:0]         w_lo;

   // Shift instead of slicing so FUNCT_W == 6 still elaborates cleanly.
   assign w_hi = funct >> 6;
   assign w_lo = funct[5:0];

   always_comb begin
      w_dec = '{code: C_NOP, ill: 1'b0, is_mul: 1'b0, is_div: 1'b0};
      case (alu_op)
         2'b00: w_dec.code = C_ADD;
         2'b01: w_dec.code = C_SUB;
         2'b11: w_dec.code = C_OR;
         default: begin
            if (|w_hi) begin
               w_dec.ill = 1'b1;
            end else begin
               case (w_lo)
                  6'b100000: w_dec.code = C_ADD;
                  6'b100010: w_dec.code = C_SUB;
                  6'b100100: w_dec.code = C_AND;
                  6'b100101: w_dec.code = C_OR;
                  6'b100110: w_dec.code = C_XOR;
                  6'b101010: w_dec.code = C_SLT;
                  6'b000000: w_dec.code = C_SLL;
                  6'b000010: w_dec.code = C_SRL;
                  6'b011000: begin w_dec.code = C_MUL; w_dec.is_mul = 1'b1; end
                  6'b011010: begin w_dec.code = C_DIV; w_dec.is_div = 1'b1; end
                  default:   w_dec.ill = 1'b1;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         ctl_out   <= '0;
         ctl_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         ctl_valid <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
         if (flush) begin
            // Flush wins over any accept or completion; no done pulse.
            r_state <= IDLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            ctl_out <= CTL_W'(C_NOP);
         end else begin
            case (r_state)
               IDLE: begin
                  if (valid_in) begin
                     ctl_out   <= CTL_W'(w_dec.code);
                     ctl_valid <= 1'b1;
                     illegal   <= w_dec.ill;
                     if (w_dec.is_mul || w_dec.is_div) begin
                        r_cnt   <= w_dec.is_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                        busy    <= 1'b1;
                        r_state <= MULTI;
                     end
                  end
               end
               MULTI: begin
                  // Counter loaded with N-1 plus the terminal edge gives N busy cycles.
                  if (r_cnt == '0) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
